// File: rtl/mips_lite_pkg.sv
// Shared types and constants for the MIPS_Lite fetch/decode/control sequencer.
// Instruction layout: op[15:13] rs[12:10] rt[9:7] rd[6:4] ls_we[3] reserved[2:0].
package mips_lite_pkg;

    localparam int INSTR_W = 16;

    localparam logic [2:0]         OP_LS      = 3'b111;
    localparam logic [INSTR_W-1:0] HALT_INSTR = 16'hFFFF;

    localparam int OP_MSB    = 15;
    localparam int OP_LSB    = 13;
    localparam int RS_MSB    = 12;
    localparam int RS_LSB    = 10;
    localparam int RT_MSB    = 9;
    localparam int RT_LSB    = 7;
    localparam int RD_MSB    = 6;
    localparam int RD_LSB    = 4;
    localparam int LS_WE_BIT = 3;

    localparam logic WB_ALU = 1'b0;
    localparam logic WB_MEM = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_e;

    typedef struct packed {
        logic [2:0] op;
        logic [2:0] rs;
        logic [2:0] rt;
        logic [2:0] rd;
        logic       ls_we;
        logic       is_halt;
        logic       is_ls;
        logic       is_store;
    } decoded_t;

endpackage

// File: rtl/mips_lite_instr_decode.sv
// Combinational field extractor for a MIPS_Lite instruction word.
// The halt word shares op=3'b111 with load/save, so is_ls excludes it.
module mips_lite_instr_decode
    import mips_lite_pkg::*;
(
    input  logic [INSTR_W-1:0] instr_i,
    output decoded_t           dec_o
);

    always_comb begin
        dec_o          = '0;
        dec_o.op       = instr_i[OP_MSB:OP_LSB];
        dec_o.rs       = instr_i[RS_MSB:RS_LSB];
        dec_o.rt       = instr_i[RT_MSB:RT_LSB];
        dec_o.rd       = instr_i[RD_MSB:RD_LSB];
        dec_o.ls_we    = instr_i[LS_WE_BIT];
        dec_o.is_halt  = (instr_i == HALT_INSTR);
        dec_o.is_ls    = (instr_i[OP_MSB:OP_LSB] == OP_LS) && !dec_o.is_halt;
        dec_o.is_store = dec_o.is_ls && instr_i[LS_WE_BIT];
    end

endmodule

// File: rtl/mips_lite_fetch_ctrl.sv
// Multicycle fetch/decode/control sequencer feeding the MIPS_Lite register file.
// State | meaning
//   IDLE   | waiting for start
//   FETCH  | imem_req high, waiting for imem_ack
//   DECODE | IR decoded, register indices latched
//   EXEC   | register file / ALU settle
//   MEM    | dmem_req high, waiting for dmem_ack
//   WB     | one-cycle reg_write strobe
//   HALT   | absorbing until reset
module mips_lite_fetch_ctrl
    import mips_lite_pkg::*;
#(
    parameter int PC_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                imem_req,
    output logic [PC_W-1:0]     imem_addr,
    input  logic                imem_ack,
    input  logic [INSTR_W-1:0]  imem_data,
    output logic                dmem_req,
    output logic                dmem_we,
    input  logic                dmem_ack,
    output logic [2:0]          ALU_op,
    output logic [2:0]          rs_in,
    output logic [2:0]          rt_in,
    output logic [2:0]          rd_in,
    output logic                reg_write,
    output logic                wb_sel,
    output logic                busy,
    output logic                halted
);

    state_e               state_q, state_d;
    logic [PC_W-1:0]      pc_q, pc_d;
    logic [INSTR_W-1:0]   ir_q, ir_d;
    logic [2:0]           alu_op_q, alu_op_d;
    logic [2:0]           rs_q, rs_d;
    logic [2:0]           rt_q, rt_d;
    logic [2:0]           rd_q, rd_d;
    logic                 wb_sel_q, wb_sel_d;
    logic                 imem_req_q, imem_req_d;
    logic                 dmem_req_q, dmem_req_d;
    logic                 dmem_we_q, dmem_we_d;
    logic                 reg_write_q, reg_write_d;
    logic                 busy_q, busy_d;
    logic                 halted_q, halted_d;
    decoded_t             dec;

    mips_lite_instr_decode u_decode (
        .instr_i (ir_q),
        .dec_o   (dec)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            pc_q        <= '0;
            ir_q        <= '0;
            alu_op_q    <= '0;
            rs_q        <= '0;
            rt_q        <= '0;
            rd_q        <= '0;
            wb_sel_q    <= WB_ALU;
            imem_req_q  <= 1'b0;
            dmem_req_q  <= 1'b0;
            dmem_we_q   <= 1'b0;
            reg_write_q <= 1'b0;
            busy_q      <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            alu_op_q    <= alu_op_d;
            rs_q        <= rs_d;
            rt_q        <= rt_d;
            rd_q        <= rd_d;
            wb_sel_q    <= wb_sel_d;
            imem_req_q  <= imem_req_d;
            dmem_req_q  <= dmem_req_d;
            dmem_we_q   <= dmem_we_d;
            reg_write_q <= reg_write_d;
            busy_q      <= busy_d;
            halted_q    <= halted_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        alu_op_d = alu_op_q;
        rs_d     = rs_q;
        rt_d     = rt_q;
        rd_d     = rd_q;
        wb_sel_d = wb_sel_q;

        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    ir_d    = imem_data;
                    pc_d    = pc_q + 1'b1;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                alu_op_d = dec.op;
                rs_d     = dec.rs;
                rt_d     = dec.rt;
                rd_d     = dec.rd;
                if (dec.is_halt)    state_d = ST_HALT;
                else if (dec.is_ls) state_d = ST_MEM;
                else                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                wb_sel_d = WB_ALU;
                state_d  = ST_WB;
            end
            ST_MEM: begin
                if (dmem_ack) begin
                    if (dec.is_store) begin
                        state_d = ST_FETCH;
                    end else begin
                        wb_sel_d = WB_MEM;
                        state_d  = ST_WB;
                    end
                end
            end
            ST_WB:   state_d = ST_FETCH;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_comb begin
        imem_req_d  = (state_d == ST_FETCH);
        dmem_req_d  = (state_d == ST_MEM);
        dmem_we_d   = (state_d == ST_MEM) && dec.ls_we;
        reg_write_d = (state_d == ST_WB);
        busy_d      = (state_d != ST_IDLE) && (state_d != ST_HALT);
        halted_d    = (state_d == ST_HALT);
    end

    assign imem_req  = imem_req_q;
    assign imem_addr = pc_q;
    assign dmem_req  = dmem_req_q;
    assign dmem_we   = dmem_we_q;
    assign ALU_op    = alu_op_q;
    assign rs_in     = rs_q;
    assign rt_in     = rt_q;
    assign rd_in     = rd_q;
    assign reg_write = reg_write_q;
    assign wb_sel    = wb_sel_q;
    assign busy      = busy_q;
    assign halted    = halted_q;

endmodule

// File: tb/tb_mips_lite_fetch_ctrl.sv
// Directed bench for mips_lite_fetch_ctrl with hand-computed expectations.
module tb_mips_lite_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [15:0] imem_data;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ack;
    logic [2:0]  ALU_op;
    logic [2:0]  rs_in;
    logic [2:0]  rt_in;
    logic [2:0]  rd_in;
    logic        reg_write;
    logic        wb_sel;
    logic        busy;
    logic        halted;

    int total = 0;
    int bad   = 0;

    mips_lite_fetch_ctrl #(.PC_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_data (imem_data),
        .dmem_req  (dmem_req),
        .dmem_we   (dmem_we),
        .dmem_ack  (dmem_ack),
        .ALU_op    (ALU_op),
        .rs_in     (rs_in),
        .rt_in     (rt_in),
        .rd_in     (rd_in),
        .reg_write (reg_write),
        .wb_sel    (wb_sel),
        .busy      (busy),
        .halted    (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return {5'b0, imem_req, dmem_req, dmem_we, reg_write, wb_sel, busy, halted,
                ALU_op, rs_in, rt_in, rd_in, imem_addr};
    endfunction

    initial begin
        int req_cycles;
        rst       = 1'b0;
        start     = 1'b0;
        imem_ack  = 1'b0;
        imem_data = 16'h0000;
        dmem_ack  = 1'b0;

        // Reset and idle
        #23;
        chk("reset_outs", all_outs(), 32'h0);
        step();
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle_outs", all_outs(), 32'h0);
        end

        // Arithmetic 16'h0470: op=0 rs=1 rt=0 rd=7, zero-wait fetch
        start = 1'b1;
        step();
        chk("arith_fetch_req", {imem_req, busy, imem_addr}, {1'b1, 1'b1, 8'h00});
        start     = 1'b0;
        imem_ack  = 1'b1;
        imem_data = 16'h0470;
        step();
        chk("arith_decode", {imem_req, reg_write, imem_addr}, {1'b0, 1'b0, 8'h01});
        imem_ack = 1'b0;
        step();
        chk("arith_fields", {ALU_op, rs_in, rt_in, rd_in}, {3'd0, 3'd1, 3'd0, 3'd7});
        chk("arith_exec_nowr", {reg_write, dmem_req}, 2'b00);
        step();
        chk("arith_wb", {reg_write, wb_sel, imem_req}, 3'b100);
        step();
        chk("arith_next_fetch", {reg_write, imem_req, imem_addr}, {1'b0, 1'b1, 8'h01});

        // Load 16'hE900: op=7 rs=2 rt=2 ls_we=0, dmem_ack delayed 3 cycles
        imem_ack  = 1'b1;
        imem_data = 16'hE900;
        step();
        chk("load_decode_addr", {imem_req, imem_addr}, {1'b0, 8'h02});
        imem_ack   = 1'b0;
        req_cycles = 0;
        step();
        chk("load_fields", {ALU_op, rs_in, rt_in, rd_in}, {3'd7, 3'd2, 3'd2, 3'd0});
        for (int i = 0; i < 3; i++) begin
            if (dmem_req) req_cycles++;
            chk("load_mem_wait", {dmem_req, dmem_we, imem_req, reg_write}, 4'b1000);
            step();
        end
        if (dmem_req) req_cycles++;
        chk("load_mem_last", {dmem_req, dmem_we, imem_req}, 3'b100);
        dmem_ack = 1'b1;
        step();
        dmem_ack = 1'b0;
        chk("load_req_cycles", req_cycles, 32'd4);
        chk("load_wb", {reg_write, wb_sel, dmem_req}, 3'b110);
        step();
        chk("load_after_wb", {reg_write, imem_req, imem_addr}, {1'b0, 1'b1, 8'h02});

        // Store 16'hE508: op=7 rs=1 rt=2 ls_we=1, immediate acks
        imem_ack  = 1'b1;
        imem_data = 16'hE508;
        step();
        chk("store_decode", {imem_req, imem_addr}, {1'b0, 8'h03});
        imem_ack = 1'b0;
        dmem_ack = 1'b1;
        step();
        chk("store_mem", {dmem_req, dmem_we, reg_write}, 3'b110);
        chk("store_fields", {ALU_op, rs_in, rt_in}, {3'd7, 3'd1, 3'd2});
        step();
        dmem_ack = 1'b0;
        chk("store_back_fetch", {imem_req, dmem_req, dmem_we, reg_write, imem_addr},
            {4'b1000, 8'h03});

        // 252 more arithmetic instructions bring pc from 3 to 8'hFF
        imem_ack  = 1'b1;
        imem_data = 16'h0470;
        for (int i = 0; i < 252; i++) begin
            step();
            step();
            step();
            step();
        end
        chk("wrap_at_ff", {imem_req, imem_addr}, {1'b1, 8'hFF});
        imem_data = 16'hFFFF;
        step();
        chk("wrap_to_zero", {imem_req, imem_addr}, {1'b0, 8'h00});
        imem_ack = 1'b0;
        step();
        chk("halt_state", {halted, busy, imem_req, dmem_req, reg_write}, 5'b10000);
        start    = 1'b1;
        imem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("halt_absorb", {halted, busy, imem_req, imem_addr}, {3'b100, 8'h00});
        end
        start    = 1'b0;
        imem_ack = 1'b0;

        // Async reset while in MEM
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("rst_from_halt", all_outs(), 32'h0);
        start = 1'b1;
        step();
        start     = 1'b0;
        imem_ack  = 1'b1;
        imem_data = 16'hE900;
        step();
        imem_ack = 1'b0;
        step();
        chk("mid_mem_req", {dmem_req, busy}, 2'b11);
        #3;
        rst = 1'b0;
        #1;
        chk("async_drop", {dmem_req, busy, imem_req}, 3'b000);
        dmem_ack = 1'b1;
        step();
        step();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("late_ack_ignored", all_outs(), 32'h0);
        end
        dmem_ack = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
